// File: rtl/ecc_44_wr_enc.sv
// Write-side SECDED encoder: 44 data bits -> 51-bit {parity, data} word, main + skid buffering.
// Optional error injection enabled by defining ECC_44_WR_ENC_ERR_INJ_EN.
module ecc_44_wr_enc #(
  parameter int DATA_WIDTH   = 44,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH+PARITY_WIDTH-1:0] out_word,
  output logic [CNT_WIDTH-1:0]               enc_count,
  output logic                               busy
`ifdef ECC_44_WR_ENC_ERR_INJ_EN
  ,
  input  logic                               inj_arm,
  input  logic [1:0]                         inj_mode,
  input  logic [5:0]                         inj_pos0,
  input  logic [5:0]                         inj_pos1
`endif
);

  localparam int WORD_W = DATA_WIDTH + PARITY_WIDTH;

  // Column for bit i is the i-th value >= 3 that is not a power of two, with bit 6 forcing odd weight.
  function automatic logic [PARITY_WIDTH-1:0] calc_parity(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_WIDTH-1:0] p;
    logic [5:0]              c;
    p = '0;
    c = 6'd3;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) p = p ^ {~^c, c};
      c = c + 6'd1;
      if ((c & (c - 6'd1)) == 6'd0) c = c + 6'd1;
    end
    return p;
  endfunction

  logic              main_vld_q, main_vld_d;
  logic [WORD_W-1:0] main_word_q, main_word_d;
  logic              skid_vld_q, skid_vld_d;
  logic [WORD_W-1:0] skid_word_q, skid_word_d;
  logic              in_ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                  in_acc;
  logic                  out_xfer;
  logic [DATA_WIDTH-1:0] data_g;
  logic [WORD_W-1:0]     inj_mask;
  logic [WORD_W-1:0]     enc_word;

  assign in_acc   = in_valid && in_ready_q;
  assign out_xfer = main_vld_q && out_ready;
  assign data_g   = in_valid ? in_data : '0;
  assign enc_word = {calc_parity(data_g), data_g} ^ inj_mask;

`ifdef ECC_44_WR_ENC_ERR_INJ_EN
  logic       inj_armed_q;
  logic [1:0] inj_mode_q;
  logic [5:0] inj_pos0_q;
  logic [5:0] inj_pos1_q;

  // Out-of-range positions match no bit and therefore flip nothing.
  function automatic logic [WORD_W-1:0] bit_at(input logic [5:0] pos);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < WORD_W; b++) begin
      if (pos == 6'(b)) m[b] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    inj_mask = '0;
    if (inj_armed_q) begin
      if (inj_mode_q == 2'd1)      inj_mask = bit_at(inj_pos0_q);
      else if (inj_mode_q == 2'd2) inj_mask = bit_at(inj_pos0_q) ^ bit_at(inj_pos1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_armed_q <= 1'b0;
    end else if (inj_arm) begin
      inj_armed_q <= 1'b1;
      inj_mode_q  <= inj_mode;
      inj_pos0_q  <= inj_pos0;
      inj_pos1_q  <= inj_pos1;
    end else if (in_acc) begin
      inj_armed_q <= 1'b0;
    end
  end
`else
  assign inj_mask = '0;
`endif

  always_comb begin
    main_vld_d  = main_vld_q;
    main_word_d = main_word_q;
    skid_vld_d  = skid_vld_q;
    skid_word_d = skid_word_q;
    if (out_xfer || !main_vld_q) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_word_d = skid_word_q;
        skid_vld_d  = 1'b0;
      end else if (in_acc) begin
        main_vld_d  = 1'b1;
        main_word_d = enc_word;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (in_acc) begin
      skid_vld_d  = 1'b1;
      skid_word_d = enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_word_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_word_q <= '0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_word_q <= main_word_d;
      skid_vld_q  <= skid_vld_d;
      skid_word_q <= skid_word_d;
      in_ready_q  <= !skid_vld_d;
      if (out_xfer && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_word  = main_word_q;
  assign enc_count = cnt_q;
  assign busy      = main_vld_q || skid_vld_q;

endmodule
